btb_read_pipe: RTL

Lookup side of the 2-way branch target buffer. Each cycle it accepts a fetch PC, reads the 128-bit set from the synchronous BTB set memory, compares tags in both ways, and returns a registered prediction (hit, taken, target). Every issued lookup is held in an in-flight queue until the branch resolves. At resolution it emits the complete update bundle (old set, tag, way-hit flags, LRU way, mispredict) that the BTB write-side logic consumes.

---
 rtl/btb_pkg.sv | 81 ++++++++
 rtl/btb_read_pipe_if.sv | 50 +++++
 rtl/btb_inflight_fifo.sv | 97 +++++++++
 rtl/btb_read_pipe.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared types and field positions for the BTB lookup pipeline.
// Optional feature macro: BTB_READ_BYPASS_EN (write-side set bypass).
package btb_pkg;

    localparam int TAG_W = 27;
    localparam int IDX_W = 3;
    localparam int TGT_W = 32;
    localparam int PC_W  = 32;
    localparam int WAY_W = 64;
    localparam int SET_W = 2 * WAY_W;

    // PC field split
    localparam int PC_TAG_LO = 5;
    localparam int PC_IDX_LO = 2;

    // Way halves inside the 128-bit set: way 1 is the upper half
    localparam int WAY1_HI = 127;
    localparam int WAY1_LO = 64;
    localparam int WAY2_HI = 63;
    localparam int WAY2_LO = 0;

    // Field positions inside one 64-bit way
    localparam int WAY_VALID_BIT = 63;
    localparam int WAY_TAG_HI    = 62;
    localparam int WAY_TAG_LO    = 36;
    localparam int WAY_TGT_HI    = 35;
    localparam int WAY_TGT_LO    = 4;
    localparam int WAY_FSM_HI    = 3;
    localparam int WAY_FSM_LO    = 2;
    localparam int WAY_RSVD_HI   = 1;
    localparam int WAY_RSVD_LO   = 0;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [TGT_W-1:0] target;
        logic [1:0]       fsm;
        logic [1:0]       rsvd;
    } btb_way_t;

    // One unresolved lookup, captured at the end of S2
    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic [SET_W-1:0] set;
        logic [TAG_W-1:0] tag;
        logic             hit1;
        logic             hit2;
        logic             lru;
        logic [PC_W-1:0]  pc;
    } btb_inflight_t;

    // Bundle handed to the BTB write side at resolution
    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic [SET_W-1:0] old_set;
        logic [TAG_W-1:0] tag;
        logic             branch1;
        logic             branch2;
        logic             lru_write;
        logic             mispredicted;
    } btb_upd_t;

    function automatic logic [TAG_W-1:0] pc_tag(input logic [PC_W-1:0] pc);
        return pc[PC_W-1:PC_TAG_LO];
    endfunction

    function automatic logic [IDX_W-1:0] pc_index(input logic [PC_W-1:0] pc);
        return pc[PC_TAG_LO-1:PC_IDX_LO];
    endfunction

    function automatic btb_way_t decode_way(input logic [WAY_W-1:0] raw);
        btb_way_t w;
        w.valid  = raw[WAY_VALID_BIT];
        w.tag    = raw[WAY_TAG_HI:WAY_TAG_LO];
        w.target = raw[WAY_TGT_HI:WAY_TGT_LO];
        w.fsm    = raw[WAY_FSM_HI:WAY_FSM_LO];
        w.rsvd   = raw[WAY_RSVD_HI:WAY_RSVD_LO];
        return w;
    endfunction

endpackage

// File: rtl/btb_read_pipe_if.sv
// Signal bundle between the BTB lookup pipe and its environment
// (fetch, set memory, resolution, write side).
// Optional feature macro: BTB_READ_BYPASS_EN (wr_* ports only matter when defined).
interface btb_read_pipe_if;
    import btb_pkg::*;

    logic                lookup_valid;
    logic [PC_W-1:0]     lookup_pc;
    logic                lookup_ready;
    logic                flush;
    logic [IDX_W-1:0]    mem_raddr;
    logic [SET_W-1:0]    mem_rdata;
    logic                lru_rdata;
    logic                pred_valid;
    logic                pred_hit;
    logic                pred_taken;
    logic [TGT_W-1:0]    pred_target;
    logic                resolve_valid;
    logic                resolve_mispredicted;
    logic                upd_valid;
    logic [IDX_W-1:0]    upd_index;
    logic [SET_W-1:0]    upd_old_set;
    logic [TAG_W-1:0]    upd_tag;
    logic                upd_branch1;
    logic                upd_branch2;
    logic                upd_lru_write;
    logic                upd_mispredicted;
    logic                wr_en;
    logic [IDX_W-1:0]    wr_index;
    logic [SET_W-1:0]    wr_set;

    // Environment side
    modport master (
        output lookup_valid, lookup_pc, flush, mem_rdata, lru_rdata,
               resolve_valid, resolve_mispredicted, wr_en, wr_index, wr_set,
        input  lookup_ready, mem_raddr, pred_valid, pred_hit, pred_taken, pred_target,
               upd_valid, upd_index, upd_old_set, upd_tag, upd_branch1, upd_branch2,
               upd_lru_write, upd_mispredicted
    );

    // Lookup pipe side
    modport slave (
        input  lookup_valid, lookup_pc, flush, mem_rdata, lru_rdata,
               resolve_valid, resolve_mispredicted, wr_en, wr_index, wr_set,
        output lookup_ready, mem_raddr, pred_valid, pred_hit, pred_taken, pred_target,
               upd_valid, upd_index, upd_old_set, upd_tag, upd_branch1, upd_branch2,
               upd_lru_write, upd_mispredicted
    );

endinterface

// File: rtl/btb_inflight_fifo.sv
// Circular queue of unresolved lookups, oldest popped first, with flush.
// Optional feature macro: BTB_READ_BYPASS_EN -- a write-side set write
// refreshes every queued entry with the same index.
module btb_inflight_fifo
    import btb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  btb_inflight_t     push_entry,
    input  logic              pop,
    output btb_inflight_t     pop_entry,
    output logic [CNT_W-1:0]  count
`ifdef BTB_READ_BYPASS_EN
    ,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [SET_W-1:0]  wr_set
`endif
);

    btb_inflight_t    mem_q [DEPTH];
    btb_inflight_t    mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // Pointer and occupancy next state; pointers wrap naturally (DEPTH is a power of 2)
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage next state: optional refresh of matching entries, then the new entry
    always_comb begin
        mem_d = mem_q;
`ifdef BTB_READ_BYPASS_EN
        if (wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_q[i].index == wr_index) mem_d[i].set = wr_set;
            end
        end
`endif
        if (push) mem_d[wr_ptr_q] = push_entry;
    end

    // Head entry; a write landing on the popped entry's index is forwarded too
    always_comb begin
        pop_entry = mem_q[rd_ptr_q];
`ifdef BTB_READ_BYPASS_EN
        if (wr_en && pop_entry.index == wr_index) pop_entry.set = wr_set;
`endif
    end

    // Control state registers
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block ordering.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; an entry is only read after it was written, and the count alone defines validity.
        mem_q <= mem_d;
    end

    assign count = count_q;

endmodule

// File: rtl/btb_read_pipe.sv
// Lookup side of the 2-way BTB: S1 registers the PC and drives the set
// address, S2 compares tags on the returned set, registers the prediction
// and queues the lookup until the branch resolves.
// Optional feature macro: BTB_READ_BYPASS_EN -- a same-cycle set write from
// the write side replaces stale memory data in S2 and in the queue.
module btb_read_pipe
    import btb_pkg::*;
#(
    parameter int INFLIGHT_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    btb_read_pipe_if.slave  bus
);

    localparam int CNT_W = $clog2(INFLIGHT_DEPTH) + 1;

    // S1 holds the accepted PC while the set memory is read
    logic             s1_valid_q, s1_valid_d;
    logic [PC_W-1:0]  s1_pc_q,    s1_pc_d;

    logic             pred_valid_q,  pred_valid_d;
    logic             pred_hit_q,    pred_hit_d;
    logic             pred_taken_q,  pred_taken_d;
    logic [TGT_W-1:0] pred_target_q, pred_target_d;

    logic             upd_valid_q, upd_valid_d;
    btb_upd_t         upd_q,       upd_d;

    logic [SET_W-1:0] s2_set;
    btb_way_t         way1, way2;
    logic             hit1, hit2;
    logic             s2_fire;
    logic             accept;
    logic             pop;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   occupancy;
    btb_inflight_t    push_entry;
    btb_inflight_t    pop_entry;

    // Ready only looks at registered occupancy; a same-cycle resolve earns no credit
    assign occupancy        = {1'b0, fifo_count} + (CNT_W + 1)'(s1_valid_q);
    assign bus.lookup_ready = !bus.flush && (occupancy < (CNT_W + 1)'(INFLIGHT_DEPTH));
    assign bus.mem_raddr    = pc_index(bus.lookup_pc);
    assign accept           = bus.lookup_valid && bus.lookup_ready;
    assign s2_fire          = s1_valid_q && !bus.flush;
    assign pop              = bus.resolve_valid && (fifo_count != '0);

    // S2 set selection and tag compare
    always_comb begin
        s2_set = bus.mem_rdata;
`ifdef BTB_READ_BYPASS_EN
        if (bus.wr_en && bus.wr_index == pc_index(s1_pc_q)) s2_set = bus.wr_set;
`endif
        way1 = decode_way(s2_set[WAY1_HI:WAY1_LO]);
        way2 = decode_way(s2_set[WAY2_HI:WAY2_LO]);
        hit1 = way1.valid && (way1.tag == pc_tag(s1_pc_q));
        hit2 = way2.valid && (way2.tag == pc_tag(s1_pc_q));
    end

    // S1 capture; a flush leaves S1 empty because ready is low that cycle
    always_comb begin
        s1_valid_d = accept;
        s1_pc_d    = accept ? bus.lookup_pc : s1_pc_q;
    end

    // Prediction: way 1 wins a double hit, miss falls through to PC+4
    always_comb begin
        pred_valid_d  = 1'b0;
        pred_hit_d    = pred_hit_q;
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        if (s2_fire) begin
            pred_valid_d = 1'b1;
            pred_hit_d   = hit1 || hit2;
            if (hit1) begin
                pred_taken_d  = way1.fsm[1];
                pred_target_d = way1.target;
            end else if (hit2) begin
                pred_taken_d  = way2.fsm[1];
                pred_target_d = way2.target;
            end else begin
                pred_taken_d  = 1'b0;
                pred_target_d = s1_pc_q + 32'd4;
            end
        end
    end

    // Queue entry built from the S2 result
    always_comb begin
        push_entry.index = pc_index(s1_pc_q);
        push_entry.set   = s2_set;
        push_entry.tag   = pc_tag(s1_pc_q);
        push_entry.hit1  = hit1;
        push_entry.hit2  = hit2 && !hit1;
        push_entry.lru   = bus.lru_rdata;
        push_entry.pc    = s1_pc_q;
    end

    // Update bundle from the popped entry; fields hold between pulses
    always_comb begin
        upd_valid_d = pop;
        upd_d       = upd_q;
        if (pop) begin
            upd_d.index        = pop_entry.index;
            upd_d.old_set      = pop_entry.set;
            upd_d.tag          = pop_entry.tag;
            upd_d.branch1      = pop_entry.hit1;
            upd_d.branch2      = pop_entry.hit2;
            upd_d.lru_write    = pop_entry.lru;
            upd_d.mispredicted = bus.resolve_mispredicted;
        end
    end

    // Pipeline and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_pc_q       <= '0;
            pred_valid_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            upd_valid_q   <= 1'b0;
            upd_q         <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_pc_q       <= s1_pc_d;
            pred_valid_q  <= pred_valid_d;
            pred_hit_q    <= pred_hit_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
            upd_valid_q   <= upd_valid_d;
            upd_q         <= upd_d;
        end
    end

    btb_inflight_fifo #(
        .DEPTH      (INFLIGHT_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (bus.flush),
        .push       (s2_fire),
        .push_entry (push_entry),
        .pop        (pop),
        .pop_entry  (pop_entry),
        .count      (fifo_count)
`ifdef BTB_READ_BYPASS_EN
        ,
        .wr_en      (bus.wr_en),
        .wr_index   (bus.wr_index),
        .wr_set     (bus.wr_set)
`endif
    );

    assign bus.pred_valid       = pred_valid_q;
    assign bus.pred_hit         = pred_hit_q;
    assign bus.pred_taken       = pred_taken_q;
    assign bus.pred_target      = pred_target_q;
    assign bus.upd_valid        = upd_valid_q;
    assign bus.upd_index        = upd_q.index;
    assign bus.upd_old_set      = upd_q.old_set;
    assign bus.upd_tag          = upd_q.tag;
    assign bus.upd_branch1      = upd_q.branch1;
    assign bus.upd_branch2      = upd_q.branch2;
    assign bus.upd_lru_write    = upd_q.lru_write;
    assign bus.upd_mispredicted = upd_q.mispredicted;

    // Fields carried for completeness but not consumed here
    logic unused_bits;
`ifdef BTB_READ_BYPASS_EN
    assign unused_bits = ^{pop_entry.pc, way1.rsvd, way2.rsvd, way1.fsm[0], way2.fsm[0]};
`else
    assign unused_bits = ^{pop_entry.pc, way1.rsvd, way2.rsvd, way1.fsm[0], way2.fsm[0],
                           bus.wr_en, bus.wr_index, bus.wr_set};
`endif

endmodule
